// File: rtl/protocol_pkg.sv
// protocol_pkg: receive FSM states and frame bit levels shared with the upstream FSM
package protocol_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/protocol_hold_reg.sv
// protocol_hold_reg: one-entry valid/ready holding register
module protocol_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         slot_free
);

    assign slot_free = !out_valid || out_ready;

    // a load in the same cycle as a consume keeps the slot full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= data_in;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/protocol_rx_deser.sv
// protocol_rx_deser: deserializes start/data/stop frames into words on a valid/ready output
module protocol_rx_deser
    import protocol_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(DATA_W);

    rx_state_t         state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_next;
    logic              slot_free;
    logic              load;
    logic              err_event;

    assign sr_next   = MSB_FIRST ? {sr[DATA_W-2:0], din} : {din, sr[DATA_W-1:1]};
    assign load      = (state == RX_STOP) && (din == STOP_BIT) && slot_free;
    assign err_event = (state == RX_STOP) && ((din != STOP_BIT) || !slot_free);
    assign busy      = (state != RX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            if (err_event && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
            case (state)
                RX_IDLE: begin
                    if (din == START_BIT) begin
                        state   <= RX_DATA;
                        bit_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    sr      <= sr_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DATA_W - 1))
                        state <= RX_STOP;
                end
                RX_STOP: begin
                    state     <= RX_IDLE;
                    frame_err <= (din != STOP_BIT);
                    overflow  <= (din == STOP_BIT) && !slot_free;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    protocol_hold_reg #(.W(DATA_W)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_in   (sr),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .slot_free (slot_free)
    );

endmodule
